proc_issuer: RTL

//  Instruction-issue side of the proc setup handshake. Buffers SIMD commands in a small FIFO.
//  For each command it wakes an idle proc and sends LD, LD, INFO and STORE, one per cycle.
//  It waits for the proc's finish flag, then returns the finish acknowledge.

---
 rtl/proc_issuer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/proc_issuer.sv
// rtl/proc_issuer.sv - buffers SIMD commands and issues EN, LD, LD, INFO, STORE to one proc,
// then waits for the proc's finish flag and returns the finish acknowledge.
module proc_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 16,
  parameter int ADDR_W     = 32,
  parameter int OP_W       = 4,
  parameter int COUNT_W    = 12,
  parameter int OPC_W      = 3,
  localparam int INFO_W    = OP_W + COUNT_W,
  localparam int INSTR_W   = OPC_W + ADDR_W
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [ADDR_W-1:0]  i_cmd_addr0,
  input  logic [ADDR_W-1:0]  i_cmd_addr1,
  input  logic [INFO_W-1:0]  i_cmd_info,
  input  logic [ADDR_W-1:0]  i_cmd_wr_addr,
  output logic               o_en,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  input  logic               i_busy,
  input  logic               i_finish,
  output logic               o_done,
  output logic [CNT_W-1:0]   o_done_cnt,
  output logic               o_idle,
  output logic               o_timeout
);

  localparam logic [OPC_W-1:0] INSTR_NOP   = OPC_W'(0);
  localparam logic [OPC_W-1:0] INSTR_LD    = OPC_W'(1);
  localparam logic [OPC_W-1:0] INSTR_INFO  = OPC_W'(2);
  localparam logic [OPC_W-1:0] INSTR_STORE = OPC_W'(3);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CMD_W = 3 * ADDR_W + INFO_W;
  // Counter must hold TIMEOUT+1 so the saturated value never wraps back onto the trigger.
  localparam int WD_W  = $clog2(TIMEOUT + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_POP, S_EN, S_LD0, S_LD1, S_INFO, S_STORE, S_WAIT_FIN, S_ACK, S_DRAIN
  } state_t;

  state_t r_state, w_state_nxt;

  logic [PTR_W:0]       r_wr_ptr, r_rd_ptr;
  logic [CMD_W-1:0]     r_mem [FIFO_DEPTH];
  logic [CMD_W-1:0]     r_cmd;
  logic                 w_full, w_empty, w_push, w_pop;
  logic [ADDR_W-1:0]    w_cmd_addr0, w_cmd_addr1, w_cmd_wr;
  logic [INFO_W-1:0]    w_cmd_info;
  logic                 w_valid_nxt;
  logic [INSTR_W-1:0]   w_instr_nxt;
  logic [WD_W-1:0]      r_wd_cnt, w_wd_inc;

  // Pointers carry one extra wrap bit: equal low bits with differing wrap bit means full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_push  = i_cmd_valid && !w_full;
  assign w_pop   = (r_state == S_POP);

  assign o_cmd_ready = !w_full;
  assign o_idle      = (r_state == S_IDLE) && w_empty;

  assign {w_cmd_addr0, w_cmd_addr1, w_cmd_info, w_cmd_wr} = r_cmd;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= {i_cmd_addr0, i_cmd_addr1, i_cmd_info, i_cmd_wr_addr};
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cmd    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        r_cmd    <= r_mem[r_rd_ptr[PTR_W-1:0]];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (!w_empty && !i_busy) w_state_nxt = S_POP;
      S_POP:      w_state_nxt = S_EN;
      S_EN:       w_state_nxt = S_LD0;
      S_LD0:      w_state_nxt = S_LD1;
      S_LD1:      w_state_nxt = S_INFO;
      S_INFO:     w_state_nxt = S_STORE;
      S_STORE:    w_state_nxt = S_WAIT_FIN;
      S_WAIT_FIN: if (i_finish) w_state_nxt = S_ACK;
      S_ACK:      w_state_nxt = S_DRAIN;
      S_DRAIN:    if (!i_finish) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with the state they belong to.
  always_comb begin
    w_valid_nxt = 1'b0;
    w_instr_nxt = '0;
    case (w_state_nxt)
      S_LD0:   begin w_valid_nxt = 1'b1; w_instr_nxt = {INSTR_LD, w_cmd_addr0}; end
      S_LD1:   begin w_valid_nxt = 1'b1; w_instr_nxt = {INSTR_LD, w_cmd_addr1}; end
      S_INFO:  begin w_valid_nxt = 1'b1; w_instr_nxt = {INSTR_INFO, ADDR_W'(w_cmd_info)}; end
      S_STORE: begin w_valid_nxt = 1'b1; w_instr_nxt = {INSTR_STORE, w_cmd_wr}; end
      S_ACK:   begin w_valid_nxt = 1'b1; w_instr_nxt = {INSTR_NOP, {ADDR_W{1'b0}}}; end
      default: begin w_valid_nxt = 1'b0; w_instr_nxt = '0; end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_en       <= 1'b0;
      o_valid    <= 1'b0;
      o_instr    <= '0;
      o_done     <= 1'b0;
      o_done_cnt <= '0;
    end else begin
      o_en    <= (w_state_nxt == S_EN);
      o_valid <= w_valid_nxt;
      o_instr <= w_instr_nxt;
      o_done  <= (w_state_nxt == S_ACK);
      if (w_state_nxt == S_ACK) o_done_cnt <= o_done_cnt + CNT_W'(1);
    end
  end

  assign w_wd_inc = r_wd_cnt + WD_W'(1);

  // Watchdog only flags a stuck proc; the FSM keeps waiting for i_finish regardless.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wd_cnt  <= '0;
      o_timeout <= 1'b0;
    end else begin
      if (r_state != S_WAIT_FIN)             r_wd_cnt <= '0;
      else if (r_wd_cnt != WD_W'(TIMEOUT))   r_wd_cnt <= w_wd_inc;
      if (TIMEOUT != 0 && r_state == S_WAIT_FIN && w_wd_inc == WD_W'(TIMEOUT))
        o_timeout <= 1'b1;
    end
  end

endmodule
